// File: rtl/chunked_adder_seq.sv
// chunked_adder_seq: WIDTH-bit adder built from one shared CHUNK-bit slice.
// One chunk is added per clock, LSB chunk first, with a registered carry
// between chunks. Valid/ready handshake on both the operand and result sides.
// Optional feature macro: ADD_SUB_EN (enables subtraction through the sub port).
module chunked_adder_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e r_state;
  state_e w_state_d;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic             r_carry;
  logic             r_cout;
  logic [IDXW-1:0]  r_idx;

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK:0]   w_sum;
  logic [WIDTH-1:0] w_s_d;
  logic             w_last;
  logic             w_accept;
  logic             w_run;
  logic [WIDTH-1:0] w_b_load;
  logic             w_carry_init;

`ifdef ADD_SUB_EN
  // Subtraction as a + ~b + 1: invert B at capture and seed the carry with 1.
  assign w_b_load     = sub ? ~b : b;
  assign w_carry_init = sub;
`else
  logic w_unused_sub;
  assign w_b_load     = b;
  assign w_carry_init = 1'b0;
  assign w_unused_sub = sub;
`endif

  assign w_accept = (r_state == StIdle) && in_valid;
  assign w_run    = (r_state == StRun);
  assign w_last   = (r_idx == IDXW'(NCHUNK - 1));

  // Select the operand chunks addressed by the chunk index.
  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_a_chunk = r_a[i*CHUNK +: CHUNK];
        w_b_chunk = r_b[i*CHUNK +: CHUNK];
      end
    end
  end

  // Shared adder slice; the top bit is the carry into the next chunk.
  assign w_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};

  // Merge the freshly computed chunk into the partial sum.
  always_comb begin
    w_s_d = r_s;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_s_d[i*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state and handshake outputs, all decoded from the state alone.
  always_comb begin
    w_state_d = r_state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_d = StRun;
        end
      end
      StRun: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_d = StDone;
        end
      end
      StDone: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Operand capture and chunk-serial datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= w_b_load;
      r_carry <= w_carry_init;
      r_idx   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
    end else if (w_run) begin
      r_s     <= w_s_d;
      r_carry <= w_sum[CHUNK];
      if (w_last) begin
        r_idx  <= '0;
        r_cout <= w_sum[CHUNK];
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign s    = r_s;
  assign cout = r_cout;

endmodule
